mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the single-port initiator bus used by the team's FSM engines (mem_req/mem_write/mem_addr/mem_wdata/mem_rdata), e.g. the matmul engine.
- Holds a synchronous word array with fixed, pipelined, non-stalling read latency and single-cycle writes.
- Has a backdoor load port for bench/host preload, plus sticky error flags.
- Sits between an initiator FSM and on-chip storage.

Parameters:
- MEM_AW, 16, address width.
- MEM_DW, 32, data width.
- DEPTH, 1024, number of implemented words; legal addresses are 0..DEPTH-1, and DEPTH <= 2**MEM_AW.
- RD_LAT, 2, read latency in cycles, >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mem_req  in  1  request valid; sampled every rising edge, no ready/backpressure
- mem_write  in  1  1=write, 0=read; qualified by mem_req
- mem_addr  in  MEM_AW  word address
- mem_wdata  in  MEM_DW  write data
- mem_rdata  out  MEM_DW  read data
- mem_rvalid  out  1  mem_rdata carries a new read result this cycle
- ld_en  in  1  backdoor write strobe
- ld_addr  in  MEM_AW  backdoor address
- ld_data  in  MEM_DW  backdoor data
- err_oor  out  1  sticky: out-of-range access seen
- err_wr_conflict  out  1  sticky: initiator write dropped due to ld_en

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low. On reset, mem_rdata=0, mem_rvalid=0, err_oor=0, err_wr_conflict=0, and all read-pipeline valid bits clear.
- Array contents are not reset and are preserved across reset.
- Reset mid-operation discards all in-flight reads; no mem_rvalid pulses for them after release.
- Read accept: mem_req=1 and mem_write=0 in cycle t. The array is read at the end of t, read-before-write (same-edge write to the same address is not visible).
- Read pipeline: result shifts through RD_LAT register stages. mem_rdata=array[addr] and mem_rvalid=1 throughout cycle t+RD_LAT.
- One read may be accepted every cycle: fully pipelined, back-to-back, in order.
- Idle output: mem_rdata holds its last value when no result is emerging; mem_rvalid=0.
- Write: mem_req=1 and mem_write=1 in cycle t writes mem_wdata at the end of t. A read accepted in t+1 to the same address returns the new data.
- mem_write with mem_req=0 is ignored.
- Backdoor: ld_en=1 writes ld_data to ld_addr at the end of the cycle. It has priority over an initiator write the same cycle:
  - the initiator write is dropped;
  - err_wr_conflict is set, regardless of address.
- An initiator read in the same cycle as ld_en proceeds normally.
- Out of range (addr >= DEPTH, initiator or backdoor):
  - a read still occupies its pipeline slot and returns 0 with mem_rvalid=1;
  - a write is dropped;
  - err_oor is set in all cases.
- Sticky flags clear only on reset.
- No internal FSM beyond the pipeline; each stage has {valid, data, oor}. Stage 1 loads on an accepted read; stage n loads from stage n-1.
- Address compare is unsigned over the full MEM_AW width.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- When defined, adds outputs:
  - rd_count (32 bits): counts accepted initiator reads.
  - wr_count (32 bits): counts committed initiator writes; dropped writes are excluded.
- Counters reset to 0, wrap modulo 2**32, and ignore backdoor loads.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Preload via ld_en addr 5=0x11, 6=0x22, then back-to-back reads of 5 and 6 in cycles 10 and 11 -> mem_rdata=0x11 with mem_rvalid=1 in cycle 12, 0x22 in cycle 13, rvalid=0 in cycle 14 with rdata holding 0x22.
2. Write 0xDEAD to addr 7 in cycle t, read 7 in t+1 -> 0xDEAD in t+3. Read 7 and write 0xBEEF to 7 in the same cycle is impossible on one port; use ld_en=0xBEEF to addr 7 concurrent with a read of 7 -> read returns 0xDEAD, and a subsequent read returns 0xBEEF.
3. ld_en to addr 3 (0xAAAA) concurrent with initiator write to addr 4 (0x5555) -> addr 3=0xAAAA, addr 4 unchanged, err_wr_conflict=1 and sticky.
4. DEPTH=1024, read addr 0x0400 -> rvalid pulse with rdata=0, err_oor=1. Write to 0xFFFF -> no array change anywhere.
5. Issue reads in cycles 20 and 21, assert rst_n=0 asynchronously mid-cycle 21 for 2 cycles -> mem_rdata=0 and mem_rvalid=0 immediately, no rvalid after release. Preloaded data still readable.
6. Run the matmul engine against the responder with RD_LAT=2, 2x2 A=[1,2;3,4], B=[5,6;7,8] -> C region holds 19,22,43,50. With MEM_RESP_STATS_EN: wr_count=4 and rd_count matches the engine's issued reads.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: pipelined-read word memory with backdoor load and sticky errors; MEM_RESP_STATS_EN adds rd/wr counters
module mem_responder #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              mem_rvalid,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [MEM_DW-1:0] ld_data,
  output logic              err_oor,
  output logic              err_wr_conflict
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [MEM_DW-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] valid_q, oor_q;
  logic [MEM_DW-1:0] data_q [RD_LAT];
  logic rd_oor, ld_oor, rd_acc, wr_req, wr_commit, ld_commit;
  logic [IW-1:0] rd_idx, ld_idx;
  logic err_oor_q, err_oor_d, err_conf_q, err_conf_d;
  always_comb begin
    rd_oor     = {1'b0, mem_addr} >= (MEM_AW+1)'(DEPTH);
    ld_oor     = {1'b0, ld_addr} >= (MEM_AW+1)'(DEPTH);
    rd_idx     = rd_oor ? '0 : mem_addr[IW-1:0];
    ld_idx     = ld_oor ? '0 : ld_addr[IW-1:0];
    rd_acc     = mem_req & ~mem_write;
    wr_req     = mem_req & mem_write;
    ld_commit  = ld_en & ~ld_oor;
    wr_commit  = wr_req & ~ld_en & ~rd_oor;
    err_oor_d  = err_oor_q | (mem_req & rd_oor) | (ld_en & ld_oor);
    err_conf_d = err_conf_q | (ld_en & wr_req);
  end
  // array has no reset so its contents survive rst_n
  always_ff @(posedge clk)
    if (ld_commit) mem[ld_idx] <= ld_data;
    else if (wr_commit) mem[rd_idx] <= mem_wdata;
  // stage data holds while its valid is low, so the last result lingers on mem_rdata
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q    <= '0;
      oor_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
      err_oor_q  <= 1'b0;
      err_conf_q <= 1'b0;
    end else begin
      valid_q[0] <= rd_acc;
      if (rd_acc) begin
        data_q[0] <= mem[rd_idx];
        oor_q[0]  <= rd_oor;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          oor_q[i]  <= oor_q[i-1];
        end
      end
      err_oor_q  <= err_oor_d;
      err_conf_q <= err_conf_d;
    end
  assign mem_rdata       = oor_q[RD_LAT-1] ? '0 : data_q[RD_LAT-1];
  assign mem_rvalid      = valid_q[RD_LAT-1];
  assign err_oor         = err_oor_q;
  assign err_wr_conflict = err_conf_q;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_q + 32'(rd_acc);
      wr_cnt_q <= wr_cnt_q + 32'(wr_commit);
    end
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif
endmodule
